layer_mac_engine: RTL and testbench
===================================

# layer_mac_engine

- Sequences one dense layer of the network against the signed 8-bit weight ROM.
- Per neuron: drives the ROM address and consumes the returned weight one cycle later. Multiply-accumulates against a latched activation vector, then adds the bias.
- Post-processing: rescales, applies the activation, saturates, and emits one 8-bit result per neuron over a valid/ready stream.
- Sits directly downstream of the weight ROM and upstream of the next layer or the output classifier.

## Interface

Parameters:
- N_IN, 6: activations per neuron (weights per neuron).
- N_OUT, 13: neurons in the layer.
- W_BASE, 0: ROM address of neuron 0 weight 0.
- FRAC_BITS, 6: fractional bits of weights/activations (Q1.6).
- ACC_W, 20: signed accumulator width.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: activation vector offered.
- in_ready, output, 1: engine idle, vector accepted.
- in_data, input, 8*N_IN: signed activations; element k at bits [8k+7:8k].
- w_addr, output, 8: ROM address, registered.
- w_data, input, 8: signed weight returned by ROM for previous-cycle w_addr.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts result.
- out_data, output, 8: signed neuron result.
- out_idx, output, 8: neuron index of out_data.
- out_last, output, 1: out_idx == N_OUT-1.
- busy, output, 1: not in IDLE.

## Operation

- ROM layout is neuron-major, N_IN+1 entries per neuron: weights k=0..N_IN-1, then bias.
- Address of entry k for neuron j: W_BASE + j*(N_IN+1) + k.
- State machine:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready, latch in_data, j=0, go to FETCH.
  - FETCH: issue addresses k=0..N_IN, one per cycle. Accumulate w_data*act[k-1] one cycle behind.
  - DRAIN: consume the bias cycle (acc += bias <<< FRAC_BITS), then go to POST.
  - POST: r = acc >>> FRAC_BITS (arithmetic), activation, saturate to 8 bits. Register into out_data, set out_valid, go to EMIT.
  - EMIT: hold until out_ready. On handshake, if j==N_OUT-1 go to IDLE, else j++, clear acc, go to FETCH.
- Arithmetic:
  - Products are 16-bit signed, sign-extended to ACC_W.
  - No overflow detection in the accumulator; ACC_W must be at least 16+clog2(N_IN+2).
- Saturation clamps to [-128,127].
- in_valid while busy is ignored. in_data is sampled only at accept.

## Timing

- Reset values: in_ready=0 during reset, then 1 (IDLE). out_valid=0, out_data=0, out_idx=0, out_last=0, w_addr=W_BASE, busy=0. Accumulator is cleared.
- ROM latency is exactly one cycle: w_data at posedge t+1 corresponds to w_addr registered at posedge t.
- Accept at cycle 0:
  - First address at cycle 1.
  - Bias address at cycle N_IN+1.
  - out_valid rises at cycle N_IN+3 (cycle 9 with defaults).
- Output handshake at cycle h: next neuron's first address at h+1, next out_valid at h+N_IN+3.
- Backpressure: while out_valid&&!out_ready, out_data, out_idx, out_last and w_addr are held stable.
- After the final handshake: in_ready=1 on the next cycle. Back-to-back vectors are accepted from then on.
- Reset mid-operation: rst_n low at any posedge forces all reset values on the next cycle. The in-flight vector is discarded with no partial output.

## Configuration

- LAYER_MAC_RELU_EN defined: negative r becomes 0, and out_data lies in [0,127]. Used for hidden layers.
- Not defined: signed saturation of r to [-128,127]. Used for the output layer.

## Structure

- Shared package nar_pkg:
  - ACT_W=8, PROD_W=16.
  - State enum (IDLE, FETCH, DRAIN, POST, EMIT).
  - Saturation/rounding function.
- Sub-module mac_unit: signed 8x8 multiply plus ACC_W accumulator, with clear and enable inputs.
- The top level owns the FSM, address generation and the output register.

## Test plan

- All-zero vector, default ROM contents: neuron 0 yields 31 (bias 0x1F), neuron 1 yields 41, neuron 2 yields 0 with LAYER_MAC_RELU_EN and -77 without.
- All activations 64 (1.0): neuron 0 raw 183+31=214, so out_data=127 (saturated).
- Address trace: accept at cycle 0 gives w_addr 0,1,...,6 on cycles 1..7; out_valid at cycle 9. Neuron 1 starts at address 7.
- Backpressure: out_ready low for 5 cycles on neuron 3 keeps out_data, out_idx=3 and w_addr stable. The next neuron is issued one cycle after the handshake.
- Full layer: 13 outputs with out_idx 0..12 and out_last only on idx 12; in_ready=1 the cycle after. A second vector presented at that cycle is accepted.
- Reset mid-layer: rst_n low during FETCH of neuron 4 gives reset values next cycle; a new vector restarts at w_addr=0, out_idx=0.

Source files
------------

// File: rtl/nar_pkg.sv
// ---------------------------------------------------------------------------
// nar_pkg
//   Types and helpers shared by the dense-layer datapath.
//
//   ACT_W   : width of one activation / weight / result (signed Q1.6)
//   PROD_W  : width of one signed ACT_W x ACT_W product
//   state_t : layer sequencer states
//   sat_s8  : clamp a wide signed value into the signed 8-bit result range
// ---------------------------------------------------------------------------
package nar_pkg;

  localparam int ACT_W  = 8;
  localparam int PROD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    POST,
    EMIT
  } state_t;

  // Clamp to [-128,127]. The caller has already rescaled, so this is a pure
  // saturating narrow with no rounding term.
  function automatic logic signed [ACT_W-1:0] sat_s8(input logic signed [31:0] v);
    logic signed [ACT_W-1:0] res;
    if (v > 32'sd127) begin
      res = 8'sh7F;
    end else if (v < -32'sd128) begin
      res = 8'sh80;
    end else begin
      res = v[ACT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
//   Signed 8x8 multiplier feeding an ACC_W-bit accumulator.
//
//   clk   in  : clock, state updates on posedge
//   rst_n in  : synchronous active-low reset, clears the accumulator
//   clr   in  : clear the accumulator (takes priority over en)
//   en    in  : add a*b into the accumulator this cycle
//   a, b  in  : signed 8-bit operands
//   acc   out : signed accumulator value
//
//   There is no overflow detection; ACC_W must cover the worst-case sum.
// ---------------------------------------------------------------------------
module mac_unit
  import nar_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [ACT_W-1:0] a,
  input  logic signed [ACT_W-1:0] b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod     = PROD_W'(a) * PROD_W'(b);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/layer_mac_engine.sv
// ---------------------------------------------------------------------------
// layer_mac_engine
//   Sequences one dense layer against an external signed 8-bit weight ROM.
//   For each neuron j it walks ROM entries W_BASE + j*(N_IN+1) + k, k=0..N_IN
//   (N_IN weights followed by the bias), multiply-accumulates the weights
//   against a latched activation vector, adds the bias, rescales by
//   FRAC_BITS, applies the activation, saturates and emits one 8-bit result
//   per neuron over a valid/ready stream.
//
//   Ports:
//     clk       in  : clock
//     rst_n     in  : synchronous active-low reset
//     in_valid  in  : activation vector offered
//     in_ready  out : engine idle, vector accepted on in_valid
//     in_data   in  : N_IN signed activations, element k at [8k+7:8k]
//     w_addr    out : registered ROM address
//     w_data    in  : ROM weight for the previous cycle's w_addr
//     out_valid out : result available
//     out_ready in  : consumer accepts result
//     out_data  out : signed neuron result
//     out_idx   out : neuron index of out_data
//     out_last  out : out_idx == N_OUT-1
//     busy      out : sequencer not idle
//
//   Build option:
//     LAYER_MAC_RELU_EN : when defined, negative results are forced to zero
//                         (hidden layers); otherwise results are signed
//                         saturated to [-128,127] (output layer).
// ---------------------------------------------------------------------------
module layer_mac_engine
  import nar_pkg::*;
#(
  parameter int N_IN      = 6,
  parameter int N_OUT     = 13,
  parameter int W_BASE    = 0,
  parameter int FRAC_BITS = 6,
  parameter int ACC_W     = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACT_W*N_IN-1:0] in_data,
  output logic [7:0]            w_addr,
  input  logic [7:0]            w_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [7:0]            out_idx,
  output logic                  out_last,
  output logic                  busy
);

  localparam int K_W = $clog2(N_IN + 1);

  localparam logic [K_W-1:0]          K_LAST = K_W'(N_IN);
  localparam logic [7:0]              STRIDE = 8'(N_IN + 1);
  localparam logic [7:0]              BASE   = 8'(W_BASE);
  localparam logic [7:0]              LAST_J = 8'(N_OUT - 1);
  // 1.0 in the weight/activation format; multiplying the bias by this
  // gives bias <<< FRAC_BITS through the same multiplier path.
  localparam logic signed [ACT_W-1:0] ONE_Q  = ACT_W'(1 << FRAC_BITS);

  state_t state, state_next;

  logic [K_W-1:0]          k_q;
  logic [7:0]              j_q;
  logic [7:0]              nbase_q;
  logic [ACT_W*N_IN-1:0]   act_vec;

  logic                    accept;
  logic                    handshake;
  logic                    mac_en;
  logic                    mac_clr;
  logic signed [ACT_W-1:0] act_sel;
  logic signed [ACT_W-1:0] mac_b;
  logic signed [ACC_W-1:0] acc;

  logic signed [ACC_W-1:0] r_shift;
  logic signed [31:0]      r_wide;
  logic signed [31:0]      r_act;
  logic signed [ACT_W-1:0] post_val;

  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes. In FETCH the weight arriving this
  // cycle belongs to the address issued at k-1, so accumulation starts at
  // k=1; the bias for address k=N_IN is consumed in DRAIN.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    handshake  = 1'b0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          mac_clr    = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        mac_en = (k_q != '0);
        if (k_q == K_LAST) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        mac_en     = 1'b1;
        state_next = POST;
      end
      POST: begin
        state_next = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          handshake  = 1'b1;
          mac_clr    = 1'b1;
          state_next = (j_q == LAST_J) ? IDLE : FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pick act[k-1] to pair with the weight that is arriving now.
  always_comb begin
    act_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (k_q == K_W'(i + 1)) begin
        act_sel = act_vec[ACT_W*i +: ACT_W];
      end
    end
  end

  assign mac_b = (state == DRAIN) ? ONE_Q : act_sel;

  mac_unit #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (w_data),
    .b     (mac_b),
    .acc   (acc)
  );

  // Post-processing: arithmetic rescale, activation, saturation.
  assign r_shift = acc >>> FRAC_BITS;
  assign r_wide  = {{(32-ACC_W){r_shift[ACC_W-1]}}, r_shift};
`ifdef LAYER_MAC_RELU_EN
  assign r_act   = r_wide[31] ? 32'sd0 : r_wide;
`else
  assign r_act   = r_wide;
`endif
  assign post_val = sat_s8(r_act);

  // Address generation, neuron bookkeeping and the output register. The
  // address and outputs only move in FETCH and POST, so they hold still
  // under output backpressure without extra gating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= '0;
      j_q       <= '0;
      nbase_q   <= BASE;
      w_addr    <= BASE;
      act_vec   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        act_vec <= in_data;
        k_q     <= '0;
        j_q     <= '0;
        nbase_q <= BASE;
      end
      if (state == FETCH) begin
        w_addr <= nbase_q + 8'(k_q);
        k_q    <= k_q + 1'b1;
      end
      if (state == POST) begin
        out_data  <= post_val;
        out_idx   <= j_q;
        out_last  <= (j_q == LAST_J);
        out_valid <= 1'b1;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        k_q       <= '0;
        j_q       <= j_q + 8'd1;
        nbase_q   <= nbase_q + STRIDE;
      end
    end
  end

endmodule

// File: tb/tb_layer_mac_engine.sv
// ---------------------------------------------------------------------------
// tb_layer_mac_engine
//   Drives layer_mac_engine with a combinational ROM model (address is
//   registered inside the DUT, so data follows one cycle later), keeps a
//   scoreboard of expected neuron results computed from the ROM contents,
//   and walks through directed steps: reset, zero vector with address
//   trace, saturating vector with backpressure, reset mid-layer, restart.
// ---------------------------------------------------------------------------
module tb_layer_mac_engine;

  localparam int N_IN      = 6;
  localparam int N_OUT     = 13;
  localparam int W_BASE    = 0;
  localparam int FRAC_BITS = 6;
  localparam int ACC_W     = 20;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] idx;
    logic       last;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [8*N_IN-1:0] in_data;
  logic [7:0]        w_addr;
  logic [7:0]        w_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [7:0]        out_idx;
  logic              out_last;
  logic              busy;

  logic [7:0] rom [0:255];
  exp_t       sb [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = -1;

  layer_mac_engine #(
    .N_IN      (N_IN),
    .N_OUT     (N_OUT),
    .W_BASE    (W_BASE),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  assign w_data = rom[w_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result for neuron j given activation vector v.
  function automatic logic [7:0] model(input int j, input logic [8*N_IN-1:0] v);
    int acc;
    int r;
    int base;
    base = W_BASE + j*(N_IN+1);
    acc = 0;
    for (int k = 0; k < N_IN; k++) begin
      acc += int'($signed(rom[base+k])) * int'($signed(v[8*k +: 8]));
    end
    acc += int'($signed(rom[base+N_IN])) * (1 << FRAC_BITS);
    r = acc >>> FRAC_BITS;
`ifdef LAYER_MAC_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return 8'(r);
  endfunction

  // Scoreboard consumer: compare every accepted output against the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e.data));
        checkOutput("out_idx", 32'(out_idx), 32'(e.idx));
        checkOutput("out_last", 32'(out_last), 32'(e.last));
        if (e.last) last_hs_cyc = cyc + 1;
      end
    end
  end

  // Queue expected results for a whole layer, offer the vector and return
  // #1 after the accepting edge (cycle 0).
  task automatic applyStimulus(input logic [8*N_IN-1:0] v);
    exp_t e;
    for (int j = 0; j < N_OUT; j++) begin
      e.data = model(j, v);
      e.idx  = 8'(j);
      e.last = (j == N_OUT-1);
      sb.push_back(e);
    end
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // From #1 after accept: addresses 0..N_IN on cycles 1..N_IN+1, out_valid
  // at cycle N_IN+3, next neuron's first address one cycle after handshake.
  task automatic traceNeuron0();
    for (int c = 1; c <= N_IN+1; c++) begin
      @(posedge clk); #1;
      checkOutput("trace_w_addr", 32'(w_addr), 32'(W_BASE + c - 1));
    end
    @(posedge clk); #1;
    checkOutput("out_valid_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("out_valid_at_9", 32'(out_valid), 32'd1);
    checkOutput("first_out_idx", 32'(out_idx), 32'd0);
    @(posedge clk); #1;
    checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("neuron1_addr", 32'(w_addr), 32'(W_BASE + N_IN + 1));
  endtask

  task automatic waitOutIdx(input int idx, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid && out_idx == 8'(idx)) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("wait_out_idx_timeout", 32'(found), 32'd1);
  endtask

  task automatic waitIdle(input int budget, output int at_cyc);
    bit found;
    found = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        found = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    checkOutput("wait_idle_timeout", 32'(found), 32'd1);
  endtask

  initial begin : stimulus
    logic [8*N_IN-1:0] vec_b;
    logic [8*N_IN-1:0] vec_c;
    logic [8*N_IN-1:0] vec_d;
    logic [7:0]        exp3;
    int                idle_cyc;

    for (int a = 0; a < 256; a++) rom[a] = 8'(((a*37 + 11) % 97) - 48);
    rom[0] = 8'd30; rom[1] = 8'd31; rom[2] = 8'd32;
    rom[3] = 8'd30; rom[4] = 8'd30; rom[5] = 8'd30;
    rom[6]  = 8'h1F;
    rom[13] = 8'd41;
    rom[20] = 8'hB3;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_w_addr", 32'(w_addr), 32'(W_BASE));
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    // Zero vector: outputs equal the (activated, saturated) biases.
    $display("[TB] zero vector, address trace, full layer");
    applyStimulus('0);
    traceNeuron0();
    waitIdle(200, idle_cyc);
    checkOutput("in_ready_after_last", 32'(in_ready), 32'd1);
    checkOutput("idle_cycle_after_last_hs", 32'(idle_cyc), 32'(last_hs_cyc));
    checkOutput("layer_a_drained", 32'(sb.size()), 32'd0);

    // All 1.0 activations, offered on the first idle cycle; neuron 0
    // saturates at 127. Backpressure on neuron 3.
    $display("[TB] saturating vector with backpressure");
    vec_b = {N_IN{8'd64}};
    exp3  = model(3, vec_b);
    checkOutput("model_n0_saturates", 32'(model(0, vec_b)), 32'd127);
    applyStimulus(vec_b);
    waitOutIdx(2, 40);
    @(posedge clk); #1;
    out_ready = 1'b0;
    waitOutIdx(3, 20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_idx", 32'(out_idx), 32'd3);
      checkOutput("bp_out_data", 32'(out_data), 32'(exp3));
      checkOutput("bp_w_addr", 32'(w_addr), 32'(W_BASE + 3*(N_IN+1) + N_IN));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp_next_addr", 32'(w_addr), 32'(W_BASE + 4*(N_IN+1)));
    waitIdle(200, idle_cyc);
    checkOutput("layer_b_drained", 32'(sb.size()), 32'd0);

    // Reset during FETCH of neuron 4; remaining outputs are discarded.
    $display("[TB] reset mid-layer");
    vec_c = {8'h20, 8'hE0, 8'h10, 8'h30, 8'hF8, 8'h40};
    applyStimulus(vec_c);
    waitOutIdx(3, 60);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("n4_fetch_addr", 32'(w_addr), 32'(W_BASE + 4*(N_IN+1)));
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_idx", 32'(out_idx), 32'd0);
    checkOutput("midrst_w_addr", 32'(w_addr), 32'(W_BASE));
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("no_partial_output", 32'(out_valid | busy), 32'd0);
    end

    // Restart with mixed-sign extremes.
    $display("[TB] restart after reset");
    vec_d = {8'hC0, 8'd64, 8'hF0, 8'd5, 8'h80, 8'h7F};
    applyStimulus(vec_d);
    traceNeuron0();
    waitIdle(200, idle_cyc);
    checkOutput("layer_d_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
